// File: rtl/mult_div_pkg.sv
// Shared definitions for the mult_and_div unit (Booth multiplier and restoring divider).
//   DEF_WIDTH : default operand/result width
//   ITER      : number of shift/add iterations per operation
//   state_e   : sequencer states used by the divider
package mult_div_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned ITER      = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StSign = 2'd2,
    StZero = 2'd3
  } state_e;

endpackage

// File: rtl/div_alu.sv
// Combinational subtractor for the divider's trial step: diff = a + ~b + 1.
//   a_i    : minuend, WIDTH+1 bits
//   b_i    : subtrahend, WIDTH+1 bits
//   diff_o : low WIDTH bits of the difference
//   neg_o  : sign (top bit) of the WIDTH+1-bit difference; 1 means a < b
module div_alu import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH:0]   b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             neg_o
);

  logic [WIDTH:0] sum;

  // Same adder shape as the multiplier ALU: invert b, carry-in of one.
  assign sum    = a_i + ~b_i + {{WIDTH{1'b0}}, 1'b1};
  assign diff_o = sum[WIDTH-1:0];
  assign neg_o  = sum[WIDTH];

endmodule

// File: rtl/div.sv
// Sequential signed divider (MIPS DIV semantics): restoring shift-subtract on
// operand magnitudes, followed by one sign-correction cycle.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : request pulse, sampled only in idle
//   dividend : signed numerator, sampled on the accepting edge
//   divisor  : signed denominator, sampled on the accepting edge
//   hi       : remainder (sign follows dividend), registered
//   lo       : quotient (truncated toward zero), registered
//   busy     : operation in progress
//   done     : one-cycle pulse when result or div_zero is valid
//   div_zero : divisor was zero; cleared by the next accepted start
module div import mult_div_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] mag_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic [CntW-1:0]  count_q;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_neg;

  // Trial operand is the remainder after shifting in the next quotient bit.
  assign trial_a = {rem_q, quo_q[WIDTH-1]};
  assign trial_b = {1'b0, mag_q};

  div_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i    (trial_a),
    .b_i    (trial_b),
    .diff_o (trial_diff),
    .neg_o  (trial_neg)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      mag_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      count_q   <= '0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              div_zero <= 1'b1;
              state_q  <= StZero;
            end else begin
              // Magnitudes are taken as unsigned, so the most negative value maps to itself.
              quo_q     <= dividend[WIDTH-1] ? -dividend : dividend;
              mag_q     <= divisor[WIDTH-1] ? -divisor : divisor;
              rem_q     <= '0;
              quo_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              rem_neg_q <= dividend[WIDTH-1];
              count_q   <= '0;
              div_zero  <= 1'b0;
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          quo_q   <= {quo_q[WIDTH-2:0], ~trial_neg};
          rem_q   <= trial_neg ? trial_a[WIDTH-1:0] : trial_diff;
          count_q <= count_q + CntW'(1);
          if (count_q == CntW'(WIDTH - 1)) begin
            state_q <= StSign;
          end
        end
        StSign: begin
          lo      <= quo_neg_q ? -quo_q : quo_q;
          hi      <= rem_neg_q ? -rem_q : rem_q;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        StZero: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int compared;
  int mismatched;

  div #(
    .WIDTH (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present operands and start for exactly one rising edge; returns #1 after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Called just after the accepting edge. lat = number of edges until done is seen
  // (sampled on falling edges), -1 on timeout. busy must be 1 before done and 0 with it.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        lat = k;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input string name);
    int lat;
    bit busy_ok;
    start_op(a, b);
    wait_done(lat, busy_ok);
    compared++;
    if (lat !== 34) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want 34", name, lat);
    end
    compared++;
    if (lo !== exp_lo) begin
      mismatched++;
      $display("FAIL %s lo: got %h want %h", name, lo, exp_lo);
    end
    compared++;
    if (hi !== exp_hi) begin
      mismatched++;
      $display("FAIL %s hi: got %h want %h", name, hi, exp_hi);
    end
    compared++;
    if (div_zero !== 1'b0) begin
      mismatched++;
      $display("FAIL %s div_zero: got %b want 0", name, div_zero);
    end
    compared++;
    if (!busy_ok) begin
      mismatched++;
      $display("FAIL %s busy profile: got wrong want high until done", name);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    compared++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
      mismatched++;
      $display("FAIL reset outputs: got hi=%h lo=%h busy=%b done=%b dz=%b want all 0",
               hi, lo, busy, done, div_zero);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_signs();
    run_div(32'd100, 32'd7, 32'd14, 32'd2, "100/7");
    run_div(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "-100/7");
    run_div(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, "100/-7");
    run_div(-32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, "-100/-7");
  endtask

  task automatic test_boundaries();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "min/-1");
    run_div(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, "max/1");
    run_div(32'd5, 32'd9, 32'd0, 32'd5, "5/9");
  endtask

  task automatic test_div_zero();
    int lat;
    bit busy_ok;
    run_div(32'd100, 32'd7, 32'd14, 32'd2, "zero-preload");
    start_op(32'd42, 32'd0);
    wait_done(lat, busy_ok);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL div0 latency: got %0d want 2", lat);
    end
    compared++;
    if (div_zero !== 1'b1) begin
      mismatched++;
      $display("FAIL div0 flag: got %b want 1", div_zero);
    end
    compared++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      mismatched++;
      $display("FAIL div0 hold: got lo=%h hi=%h want lo=0000000e hi=00000002", lo, hi);
    end
    run_div(32'd9, 32'd3, 32'd3, 32'd0, "after-div0");
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    start_op(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    compared++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      mismatched++;
      $display("FAIL abort clear: got hi=%h lo=%h busy=%b done=%b want all 0",
               hi, lo, busy, done);
    end
    @(negedge clock);
    reset     = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    compared++;
    if (seen_done) begin
      mismatched++;
      $display("FAIL abort no-done: got done pulse want none");
    end
    run_div(32'd9, 32'd3, 32'd3, 32'd0, "after-abort");
  endtask

  task automatic test_back_to_back();
    int lat;
    bit busy_ok;
    start_op(32'd100, 32'd7);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 4) begin
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
      end else if (k == 5) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    compared++;
    if (lat !== 34) begin
      mismatched++;
      $display("FAIL ignore latency: got %0d want 34", lat);
    end
    compared++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      mismatched++;
      $display("FAIL ignore result: got lo=%h hi=%h want lo=0000000e hi=00000002", lo, hi);
    end
    // Still in the done cycle: a start here must be accepted.
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(lat, busy_ok);
    compared++;
    if (lat !== 34) begin
      mismatched++;
      $display("FAIL b2b latency: got %0d want 34", lat);
    end
    compared++;
    if (lo !== 32'd3 || hi !== 32'd0) begin
      mismatched++;
      $display("FAIL b2b result: got lo=%h hi=%h want lo=00000003 hi=00000000", lo, hi);
    end
    compared++;
    if (!busy_ok) begin
      mismatched++;
      $display("FAIL b2b busy profile: got wrong want high until done");
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_signs();
    test_boundaries();
    test_div_zero();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential signed 32-bit integer divider; the counterpart of the team's Booth multiplier in the mult_and_div unit.
- Produces a quotient (lo) and a remainder (hi) for the CPU's DIV instruction.
- Implemented as restoring shift-subtract on operand magnitudes, with a final sign-correction cycle.
- The control unit starts it with a one-cycle pulse and waits for done before reading hi and lo.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is verified. The iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  signed numerator; sampled on the accepting edge.
- divisor  input  WIDTH  signed denominator; sampled on the accepting edge.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- busy  output  1  high from the edge after acceptance until the done cycle.
- done  output  1  one-cycle pulse; the cycle in which the result or div_zero becomes valid.
- div_zero  output  1  high with done when divisor == 0; cleared on the next accepted start.

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE; hi, lo, busy, done, div_zero and all internal registers = 0.
- States: IDLE, RUN, SIGN, ZERO.
- IDLE with start == 1 and divisor != 0:
  - Latch |dividend| into the quotient register Q and |divisor| into M; clear remainder R.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Set count = 0, div_zero = 0, go to RUN.
- IDLE with start == 1 and divisor == 0: go to ZERO; div_zero = 1; hi and lo unchanged.
- RUN, each edge:
  - {R,Q} shifts left by 1.
  - Trial difference T = {R,Q[msb]} − M, computed 33 bits wide.
  - T ≥ 0: R = T[31:0] and Q[0] = 1. Otherwise R is kept and Q[0] = 0.
  - count increments; after the 32nd RUN edge, go to SIGN.
- SIGN, one edge:
  - lo = neg_q ? −Q : Q; hi = neg_r ? −R : R (two's complement, truncated to WIDTH).
  - done = 1 in the following cycle; go to IDLE.
- ZERO, one edge: done = 1 in the following cycle; go to IDLE.
- Latency: with the accepting edge numbered edge 1, done is high in the cycle after edge 34 (1 load + 32 RUN + 1 SIGN). The divide-by-zero path has done high after edge 2.
- Magnitudes use unsigned 32-bit interpretation, so |0x80000000| = 0x80000000.
- 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 and hi = 0 (wraps, no trap).
- Quotient truncates toward zero; remainder takes the dividend's sign (MIPS semantics).
- start while busy, or in SIGN or ZERO, is ignored. Operand changes during an operation have no effect.
- hi and lo hold their value between operations and change only in SIGN (or on reset).
- done and start may coincide: a start in the done cycle is accepted, since the FSM is already in IDLE.
- Reset mid-operation aborts immediately: no done pulse, and outputs return to reset values.
- The subtractor is a shared combinational 33-bit adder with carry-in, the same style as the multiplier's add/sub ALU.

Decomposition:
- Shared package mult_div_pkg:
  - state encoding constants (IDLE, RUN, SIGN, ZERO);
  - WIDTH default;
  - the ITER = 32 constant, also used by the multiplier.
- One sub-module, div_alu: 33-bit a + ~b + 1 subtractor returning difference and sign. It is instantiated once.
- Sign correction uses plain negation expressions in div; no separate module.

Test Plan:
- dividend = 100, divisor = 7, start pulse → done exactly in cycle 35 after the start edge; lo = 14, hi = 2; busy high for cycles 2–34; div_zero = 0.
- −100 / 7 → lo = 0xFFFFFFF2 (−14), hi = 0xFFFFFFFE (−2). 100 / −7 → lo = −14, hi = 2. −100 / −7 → lo = 14, hi = −2.
- 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. 0x7FFFFFFF / 1 → lo = 0x7FFFFFFF, hi = 0. 5 / 9 → lo = 0, hi = 5.
- Load hi/lo via 100 / 7, then 42 / 0 → div_zero = 1 and done in the cycle after the second edge; hi = 2 and lo = 14 unchanged. Next valid start clears div_zero.
- Start 100 / 7, assert reset low at cycle 10 → hi, lo, busy and done are 0 immediately and no done pulse follows. Then 9 / 3 → lo = 3, hi = 0 with normal latency.
- Start 100 / 7, pulse start with 1 / 1 at cycle 5 → ignored; result lo = 14, hi = 2. Start 9 / 3 in the done cycle → accepted; lo = 3 after a further 34 edges.
